msg_frame_rx: RTL and testbench

MSG_FRAME_RX -- requirements
Module: msg_frame_rx

---
 rtl/msg_frame_rx.sv | 98 +++++++++
 tb/tb_msg_frame_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/msg_frame_rx.sv
// msg_frame_rx: hunts for a sync byte, collects a fixed-size payload and validates its XOR checksum
module msg_frame_rx #(
    parameter int                   WORD_SIZE        = 8,
    parameter int                   WORDS_PER_PACKET = 4,
    parameter logic [WORD_SIZE-1:0] SYNC_WORD        = 8'hA5,
    parameter int                   TIMEOUT_CLKS     = 24000
) (
    input  logic                                  clk,
    input  logic                                  n_reset,
    input  logic [WORD_SIZE-1:0]                  data_in,
    input  logic                                  data_in_valid,
    output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out,
    output logic                                  data_out_valid,
    output logic                                  err_checksum,
    output logic                                  err_timeout,
    output logic                                  busy
);
    localparam int PW = WORD_SIZE * WORDS_PER_PACKET;
    localparam int CW = $clog2(TIMEOUT_CLKS);
    localparam int IW = $clog2(WORDS_PER_PACKET + 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [WORD_SIZE-1:0] xor_acc, xor_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [PW-1:0]        stage, stage_n, dout_n;
    logic                 dv_n, ec_n, et_n;

    assign busy = (state != HUNT);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state          <= HUNT;
            idx            <= '0;
            xor_acc        <= '0;
            cnt            <= '0;
            stage          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            err_checksum   <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            xor_acc        <= xor_n;
            cnt            <= cnt_n;
            stage          <= stage_n;
            data_out       <= dout_n;
            data_out_valid <= dv_n;
            err_checksum   <= ec_n;
            err_timeout    <= et_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        xor_n   = xor_acc;
        cnt_n   = cnt;
        stage_n = stage;
        dout_n  = data_out;
        dv_n    = 1'b0;
        ec_n    = 1'b0;
        et_n    = 1'b0;
        if (state == HUNT) begin
            if (data_in_valid && data_in == SYNC_WORD) begin
                state_n = PAYLOAD;
                idx_n   = '0;
                xor_n   = '0;
                cnt_n   = '0;
            end
        end else if (!data_in_valid) begin
            // a byte landing on the limit cycle wins over the timeout
            if (cnt == CW'(TIMEOUT_CLKS - 1)) begin
                et_n    = 1'b1;
                state_n = HUNT;
                cnt_n   = '0;
                stage_n = '0;
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end else if (state == PAYLOAD) begin
            cnt_n   = '0;
            stage_n = (stage << WORD_SIZE) | PW'(data_in);
            xor_n   = xor_acc ^ data_in;
            idx_n   = idx + IW'(1);
            state_n = (idx == IW'(WORDS_PER_PACKET - 1)) ? CHECK : PAYLOAD;
        end else begin
            cnt_n   = '0;
            state_n = HUNT;
            dv_n    = (data_in == xor_acc);
            ec_n    = (data_in != xor_acc);
            dout_n  = (data_in == xor_acc) ? stage : data_out;
        end
    end
endmodule

// File: tb/tb_msg_frame_rx.sv
// tb_msg_frame_rx: randomized and directed frames scored against a byte-level reference model
module tb_msg_frame_rx;
    localparam int N  = 4;
    localparam int T  = 16;
    localparam int PW = 8 * N;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic [7:0]    data_in = '0;
    logic          data_in_valid = 1'b0;
    logic [PW-1:0] data_out;
    logic          data_out_valid, err_checksum, err_timeout, busy;

    msg_frame_rx #(.WORD_SIZE(8), .WORDS_PER_PACKET(N), .SYNC_WORD(8'hA5), .TIMEOUT_CLKS(T)) dut (
        .clk(clk), .n_reset(n_reset), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_out(data_out), .data_out_valid(data_out_valid), .err_checksum(err_checksum),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // pulse pattern {data_out_valid, err_checksum, err_timeout}, cycle it must appear, payload for good frames
    typedef struct {logic [2:0] kind; int cyc; logic [PW-1:0] data;} exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    bit         in_frame = 0;
    logic [7:0] pay[$];
    int         idle = 0;

    task automatic model(input bit v, input logic [7:0] d);
        logic [7:0]    x;
        logic [PW-1:0] p;
        if (!in_frame) begin
            if (v && d == 8'hA5) begin
                in_frame = 1;
                pay.delete();
                idle = 0;
            end
        end else if (v) begin
            idle = 0;
            if (pay.size() < N) pay.push_back(d);
            else begin
                x = 0;
                p = 0;
                foreach (pay[i]) begin
                    x = x ^ pay[i];
                    p = p * 256 + PW'(pay[i]);
                end
                exp_q.push_back('{(x == d) ? 3'b100 : 3'b010, cyc + 1, p});
                in_frame = 0;
            end
        end else begin
            idle++;
            if (idle == T) begin
                exp_q.push_back('{3'b001, cyc + 1, '0});
                in_frame = 0;
            end
        end
    endtask

    task automatic step_now(input bit v, input logic [7:0] d);
        data_in_valid = v;
        data_in = v ? d : 8'($urandom);
        model(v, d);
        @(posedge clk);
        #1 chk("busy", busy, in_frame);
    endtask

    task automatic step(input bit v, input logic [7:0] d);
        @(negedge clk);
        step_now(v, d);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic good_frame(input logic [31:0] p);
        logic [7:0] b[4];
        b[0] = p[31:24]; b[1] = p[23:16]; b[2] = p[15:8]; b[3] = p[7:0];
        step(1, 8'hA5);
        for (int i = 0; i < 4; i++) step(1, b[i]);
        step(1, b[0] ^ b[1] ^ b[2] ^ b[3]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        data_in_valid = 1'b0;
        in_frame = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_data_out", data_out, 0);
            chk("rst_busy", busy, 0);
        end
    endtask

    logic [PW-1:0] last_good = '0;
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] pulses;
        pulses = {data_out_valid, err_checksum, err_timeout};
        if (!n_reset) begin
            last_good = '0;
            chk("rst_quiet", pulses, 0);
        end else begin
            chk("onehot", $countones(pulses) <= 1, 1);
            if (pulses != 0) begin
                if (exp_q.size() == 0) chk("unexpected_pulse", pulses, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("kind", pulses, e.kind);
                    chk("latency", cyc, e.cyc);
                    if (e.kind == 3'b100) last_good = e.data;
                    chk("data_out", data_out, last_good);
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    chk("missing_pulse", pulses, e.kind);
                end
                chk("hold", data_out, last_good);
            end
        end
    end

    int gsel;
    task automatic gap();
        gsel = $urandom_range(0, 9);
        if (gsel == 6) idles($urandom_range(1, 3));
        else if (gsel == 7) idles(T - 2);
        else if (gsel == 8) idles(T - 1);
        else if (gsel == 9) idles(T);
    endtask

    initial begin
        logic [7:0] r[4];
        logic [7:0] x;
        repeat (2) @(negedge clk);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {data_out_valid, err_checksum, err_timeout}, 0);
        @(negedge clk);
        n_reset = 1'b1;
        step_now(1, 8'hA5);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h12 + 8'h22 * i));
        step(1, 8'h08);
        idles(3);
        good_frame(32'h12345678);
        idles(2);
        step(1, 8'hA5); step(1, 8'h12); step(1, 8'h34); step(1, 8'h56); step(1, 8'h78); step(1, 8'h09);
        idles(2);
        step(1, 8'h00); step(1, 8'hFF);
        repeat (6) step(1, 8'hA5);
        idles(2);
        step(1, 8'hA5); step(1, 8'h11);
        idles(T + 2);
        good_frame(32'hCAFEF00D);
        step(1, 8'hA5);
        idles(T - 1);
        step(1, 8'h21); step(1, 8'h43);
        idles(T - 1);
        step(1, 8'h65); step(1, 8'h87);
        idles(T - 1);
        step(1, 8'h21 ^ 8'h43 ^ 8'h65 ^ 8'h87);
        idles(2);
        step(1, 8'hA5); step(1, 8'h12); step(1, 8'h34);
        do_reset();
        @(negedge clk);
        n_reset = 1'b1;
        step_now(1, 8'hA5);
        step(1, 8'hDE); step(1, 8'hAD); step(1, 8'hBE); step(1, 8'hEF);
        step(1, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
        idles(2);
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) step(1, 8'($urandom));
            gap();
            step(1, 8'hA5);
            x = 0;
            for (int i = 0; i < 4; i++) begin
                r[i] = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
                x = x ^ r[i];
                gap();
                step(1, r[i]);
            end
            gap();
            step(1, ($urandom_range(0, 3) == 0) ? x ^ 8'($urandom_range(1, 255)) : x);
        end
        idles(T + 4);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
